fibonacci_index: RTL and testbench
==================================

// Module: fibonacci_index
// PURPOSE
//  Inverse of the fibonacci block: given a value din, iteratively finds the largest index n
//  with F(n) <= din and flags whether din is exactly a Fibonacci number. Same start/done
//  handshake as fibonacci, so the two blocks can be chained and cross-checked (F^-1(F(n)) == n).
// PARAMETERS
//  DATA_W   16  width of din; internal a/b registers are DATA_W+1 bits to absorb overflow
//  INDEX_W  5   width of dout; must hold the largest n with F(n) < 2**DATA_W (24 for DATA_W=16)
// PORTS
//  clk      in   1        single clock, all state on rising edge
//  reset_n  in   1        asynchronous, active-low reset
//  din      in   DATA_W   value to invert; sampled only on the cycle start is accepted
//  start    in   1        request; accepted only in IDLE or DONE
//  dout     out  INDEX_W  largest n with F(n) <= din (F(0)=0, F(1)=F(2)=1)
//  exact    out  1        1 when F(dout) == din
//  busy     out  1        1 while computing (CALC)
//  done     out  1        level; 1 from completion until the next start is accepted
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; dout=0, exact=0, busy=0, done=0.
//  - States: IDLE -> (start) CALC -> (b > target) DONE -> (start) CALC; no other transitions.
//  - On accept: target<=din, a<=0, b<=1, n<=0, done<=0, busy<=1, state<=CALC.
//  - CALC, per cycle: if b <= target {a<=b; b<=a+b; n<=n+1} else {dout<=n;
//    exact<=(a==target); busy<=0; done<=1; state<=DONE}.
//  - Compare and add are DATA_W+1 bits wide, so b never wraps (F(25)=75025 fits in 17 bits).
//  - Latency: start sampled at edge 0; CALC spans n+1 cycles; done=1 after edge n+2.
//    din=0 -> 2 edges; din=65535 -> 26 edges.
//  - dout/exact hold their values through DONE until the next accepted start.
//  - start while busy: ignored; din changes during CALC have no effect (target is latched).
//  - start in DONE: accepted that edge; done falls the edge start is sampled.
//  - din=1: dout=2 (largest index), exact=1. din=0: dout=0, exact=1.
//  - reset_n low mid-CALC: immediate abort to reset values; no done pulse is produced.
// STRUCTURE
//  - fib_pkg: state enum (IDLE, CALC, DONE), DATA_W/INDEX_W defaults, and the
//    constant FIB_MAX_IDX_16 = 24.
//  - One sub-module fib_step: combinational a+b / b<=target datapath (DATA_W+1 bits),
//    so the FSM and the counter stay in fibonacci_index.
// TESTING
//  - Reset: reset_n=0 mid-CALC (din=46368) -> dout=0, exact=0, busy=0, done=0; IDLE after release.
//  - din=0 -> dout=0, exact=1, done after 2 edges; din=1 -> dout=2, exact=1.
//  - din=5 -> 5/exact=1; din=7 -> 5/exact=0; din=46368 -> 24/exact=1; din=65535 -> 24/exact=0.
//  - Pulse start with din=23 during CALC of din=46368 -> ignored; result stays 24/exact=1.
//  - Back-to-back: start in the first DONE cycle with din=13 -> done drops next edge, then 7/exact=1.
//  - Chain with fibonacci for n=0..24: dout==n (n=1 maps to 2), exact=1; exhaustive
//    din=0..65535 vs. reference model.

Source files
------------

// File: rtl/fibonacci_index_pkg.sv
// ----------------------------------------------------------------------------
// fibonacci_index_pkg
// Shared definitions for the Fibonacci inverse-index block: FSM state type,
// default widths and the largest index representable for a 16-bit input.
// ----------------------------------------------------------------------------
package fibonacci_index_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_INDEX_W    = 5;

    // Largest n with F(n) < 2**16 (F(24) = 46368, F(25) = 75025).
    localparam int FIB_MAX_IDX_16 = 24;

endpackage

// File: rtl/fibonacci_index_if.sv
// ----------------------------------------------------------------------------
// fibonacci_index_if
// Start/done handshake bundle for fibonacci_index.
//   din   : value to invert (master -> slave)
//   start : request (master -> slave)
//   dout  : largest n with F(n) <= din (slave -> master)
//   exact : 1 when F(dout) == din (slave -> master)
//   busy  : computing (slave -> master)
//   done  : result valid, level until next accepted start (slave -> master)
// ----------------------------------------------------------------------------
interface fibonacci_index_if
    import fibonacci_index_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int INDEX_W = DEF_INDEX_W
) ();

    logic [DATA_W-1:0]  din;
    logic               start;
    logic [INDEX_W-1:0] dout;
    logic               exact;
    logic               busy;
    logic               done;

    modport master (
        output din,
        output start,
        input  dout,
        input  exact,
        input  busy,
        input  done
    );

    modport slave (
        input  din,
        input  start,
        output dout,
        output exact,
        output busy,
        output done
    );

endinterface

// File: rtl/fibonacci_index_step.sv
// ----------------------------------------------------------------------------
// fibonacci_index_step
// Combinational datapath for one iteration of the inverse search.
//   a, b   : consecutive Fibonacci terms F(n), F(n+1)
//   target : latched input value, zero-extended to W bits
//   sum    : a + b, the next term F(n+2)
//   le     : b <= target, i.e. the search may advance one more index
// W is one bit wider than the input so F(n+1) can exceed the largest input
// without wrapping.
// ----------------------------------------------------------------------------
module fibonacci_index_step #(
    parameter int W = 17
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] target,
    output logic [W-1:0] sum,
    output logic         le
);

    assign sum = a + b;
    assign le  = (b <= target);

endmodule

// File: rtl/fibonacci_index.sv
// ----------------------------------------------------------------------------
// fibonacci_index
// Given din, iteratively finds the largest n with F(n) <= din and flags
// whether din is exactly a Fibonacci number. Uses the same start/done
// handshake as the fibonacci generator so the two can be chained.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : fibonacci_index_if slave (din, start, dout, exact, busy, done)
// ----------------------------------------------------------------------------
module fibonacci_index
    import fibonacci_index_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int INDEX_W = DEF_INDEX_W
) (
    input  logic               clk,
    input  logic               reset_n,
    fibonacci_index_if.slave   bus
);

    localparam int W = DATA_W + 1;

    state_t             state;
    logic [DATA_W-1:0]  target;
    logic [W-1:0]       target_ext;
    logic [W-1:0]       a;
    logic [W-1:0]       b;
    logic [W-1:0]       sum;
    logic               le;
    logic [INDEX_W-1:0] n;

    logic [INDEX_W-1:0] dout_r;
    logic               exact_r;
    logic               busy_r;
    logic               done_r;

    logic               accept;

    // A start is honoured only outside CALC; during CALC it is ignored.
    assign accept     = bus.start && (state != CALC);
    assign target_ext = {1'b0, target};

    fibonacci_index_step #(.W(W)) u_step (
        .a      (a),
        .b      (b),
        .target (target_ext),
        .sum    (sum),
        .le     (le)
    );

    // Control and result registers: reset to a clean idle state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            dout_r  <= '0;
            exact_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        done_r <= 1'b0;
                        busy_r <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    // Stop once F(n+1) overshoots: n is then the answer and
                    // a = F(n) tells whether the input was hit exactly.
                    if (!le) begin
                        dout_r  <= n;
                        exact_r <= (a == target_ext);
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Search registers carry no reset: they are fully loaded on every accept
    // and only consulted while in CALC.
    always_ff @(posedge clk) begin
        if (accept) begin
            target <= bus.din;
            a      <= '0;
            b      <= W'(1);
            n      <= '0;
        end else if ((state == CALC) && le) begin
            a <= b;
            b <= sum;
            n <= n + INDEX_W'(1);
        end
    end

    assign bus.dout  = dout_r;
    assign bus.exact = exact_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;

endmodule

// File: tb/tb_fibonacci_index.sv
// ----------------------------------------------------------------------------
// tb_fibonacci_index
// Directed self-checking bench for fibonacci_index.
// ----------------------------------------------------------------------------
module tb_fibonacci_index;
    import fibonacci_index_pkg::*;

    localparam int DATA_W  = 16;
    localparam int INDEX_W = 5;
    localparam int MAX_EDGES = 60;

    logic clk;
    logic reset_n;

    int n_checks;
    int n_fail;
    int fib [0:25];

    fibonacci_index_if #(.DATA_W(DATA_W), .INDEX_W(INDEX_W)) bus ();

    fibonacci_index #(.DATA_W(DATA_W), .INDEX_W(INDEX_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: scan the Fibonacci table from the top for the first term <= v.
    function automatic void ref_index(input int v, output int idx, output bit ex);
        idx = 0;
        ex  = 1'b0;
        for (int k = 25; k >= 0; k--) begin
            if (fib[k] <= v) begin
                idx = k;
                ex  = (fib[k] == v);
                break;
            end
        end
    endfunction

    // Issue one start (caller is #1 after a rising edge) and wait for done.
    // edges counts the accept edge plus every edge until done is seen.
    task automatic run_op(input int v, output int res, output bit ex, output int edges);
        bus.din   = v[DATA_W-1:0];
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        edges = 1;
        while (!bus.done && edges < MAX_EDGES) begin
            @(posedge clk);
            #1;
            edges++;
        end
        res = int'(bus.dout);
        ex  = bus.exact;
        n_checks++;
        if (!bus.done) begin
            n_fail++;
            $display("FAIL timeout din=%0d: done not seen within %0d edges", v, MAX_EDGES);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.din   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        n_checks++;
        if ({bus.dout, bus.exact, bus.busy, bus.done} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: dout=%0d exact=%b busy=%b done=%b, need all 0",
                     bus.dout, bus.exact, bus.busy, bus.done);
        end
        // Abort mid-CALC
        bus.din   = 16'd46368;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_mid_calc: busy=%b, need 1", bus.busy);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.dout, bus.exact, bus.busy, bus.done} !== '0) begin
            n_fail++;
            $display("FAIL async_abort: dout=%0d exact=%b busy=%b done=%b, need all 0",
                     bus.dout, bus.exact, bus.busy, bus.done);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_abort: busy=%b done=%b, need 0/0", bus.busy, bus.done);
        end
    endtask

    task automatic test_directed();
        int din_v  [6] = '{0, 1, 5, 7, 46368, 65535};
        int exp_n  [6] = '{0, 2, 5, 5, 24, 24};
        bit exp_ex [6] = '{1, 1, 1, 0, 1, 0};
        int exp_ed [6] = '{2, 4, 7, 7, 26, 26};
        int res, edges;
        bit ex;
        for (int i = 0; i < 6; i++) begin
            run_op(din_v[i], res, ex, edges);
            n_checks++;
            if (res !== exp_n[i] || ex !== exp_ex[i]) begin
                n_fail++;
                $display("FAIL directed din=%0d: got dout=%0d exact=%b, need dout=%0d exact=%b",
                         din_v[i], res, ex, exp_n[i], exp_ex[i]);
            end
            n_checks++;
            if (edges !== exp_ed[i]) begin
                n_fail++;
                $display("FAIL latency din=%0d: got %0d edges, need %0d", din_v[i], edges, exp_ed[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic [INDEX_W-1:0] d0;
        logic e0;
        d0 = bus.dout;
        e0 = bus.exact;
        bus.din = 16'd3;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (bus.dout !== 5'd24 || bus.exact !== 1'b0 || bus.done !== 1'b1 || d0 !== 5'd24 || e0 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold: dout=%0d exact=%b done=%b, need 24/0/1", bus.dout, bus.exact, bus.done);
        end
    endtask

    task automatic test_ignore_start();
        int edges;
        bus.din   = 16'd46368;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.din   = 16'd23;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        edges = 0;
        while (!bus.done && edges < MAX_EDGES) begin
            @(posedge clk);
            #1;
            edges++;
        end
        n_checks++;
        if (bus.done !== 1'b1 || bus.dout !== 5'd24 || bus.exact !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_start: done=%b dout=%0d exact=%b, need 1/24/1",
                     bus.done, bus.dout, bus.exact);
        end
    endtask

    task automatic test_back_to_back();
        int res, edges;
        bit ex;
        run_op(8, res, ex, edges);
        n_checks++;
        if (res !== 6 || ex !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: got %0d/%b, need 6/1", res, ex);
        end
        // First DONE cycle: start again immediately.
        bus.din   = 16'd13;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done_drop: done=%b busy=%b, need 0/1", bus.done, bus.busy);
        end
        edges = 1;
        while (!bus.done && edges < MAX_EDGES) begin
            @(posedge clk);
            #1;
            edges++;
        end
        n_checks++;
        if (bus.done !== 1'b1 || bus.dout !== 5'd7 || bus.exact !== 1'b1 || edges !== 9) begin
            n_fail++;
            $display("FAIL b2b_second: done=%b dout=%0d exact=%b edges=%0d, need 1/7/1/9",
                     bus.done, bus.dout, bus.exact, edges);
        end
    endtask

    task automatic test_chain();
        int res, edges, exp_i, v;
        bit ex, exp_e;
        for (int k = 0; k <= 24; k++) begin
            run_op(fib[k], res, ex, edges);
            exp_i = (k == 1) ? 2 : k;
            n_checks++;
            if (res !== exp_i || ex !== 1'b1) begin
                n_fail++;
                $display("FAIL chain n=%0d: got %0d/%b, need %0d/1", k, res, ex, exp_i);
            end
        end
        // Neighbours of each term against the table model.
        for (int k = 3; k <= 24; k++) begin
            for (int d = -1; d <= 1; d += 2) begin
                v = fib[k] + d;
                ref_index(v, exp_i, exp_e);
                run_op(v, res, ex, edges);
                n_checks++;
                if (res !== exp_i || ex !== exp_e) begin
                    n_fail++;
                    $display("FAIL model din=%0d: got %0d/%b, need %0d/%b", v, res, ex, exp_i, exp_e);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        fib[0] = 0;
        fib[1] = 1;
        for (int k = 2; k <= 25; k++) fib[k] = fib[k-1] + fib[k-2];

        test_reset();
        test_directed();
        test_hold();
        test_ignore_start();
        test_back_to_back();
        test_chain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
